// File: rtl/cu_read_command_arbiter_pkg.sv
// cu_read_command_arbiter_pkg
//   Shared types and constants for the read-command arbiter.
//   - arb_state_type      : arbiter FSM states
//   - NUM_READ_ARB_REQUESTERS / READ_ARB_MAX_OUTSTANDING : default sizing
//   - CommandBufferLine   : read command toward the read buffer (valid = request)
//   - ResponseBufferLine  : read response return (valid retires one read)
//   - BufferStatus        : read-buffer fill flags (alfull throttles issue)
package cu_read_command_arbiter_pkg;

  localparam int NUM_READ_ARB_REQUESTERS  = 4;
  localparam int READ_ARB_MAX_OUTSTANDING = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_STALL  = 2'd2,
    ARB_DRAIN  = 2'd3
  } arb_state_type;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [7:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic [31:0] data;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

endpackage

// File: rtl/cu_read_command_arbiter_rr_arbiter.sv
// round_robin_priority_arbiter
//   Combinational round-robin pick: the first set request at or after the
//   pointer, wrapping from NUM_REQUESTERS-1 back to 0.
//   Ports:
//     request      : request vector
//     pointer      : highest-priority index this cycle
//     grant_onehot : one-hot grant (zero when no request)
//     grant_index  : index of the granted request
//     grant_valid  : at least one request present
module round_robin_priority_arbiter #(
  parameter int  NUM_REQUESTERS = 4,
  localparam int IDX_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [IDX_W-1:0]          pointer,
  output logic [NUM_REQUESTERS-1:0] grant_onehot,
  output logic [IDX_W-1:0]          grant_index,
  output logic                      grant_valid
);

  int cand;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    cand         = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = (int'(pointer) + k) % NUM_REQUESTERS;
      if (!grant_valid && request[cand]) begin
        grant_valid        = 1'b1;
        grant_index        = IDX_W'(cand);
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// cu_read_command_arbiter
//   Shares the read-command channel toward the read buffer between
//   NUM_REQUESTERS sources. Round-robin grant, one command per cycle, output
//   registered. Tracks issued-but-unanswered reads and throttles on
//   read-buffer almost-full or a full outstanding window. Dropping enabled_in
//   drains outstanding reads before returning to idle.
//   Optional feature macro: CU_READ_ARB_GRANT_STATS_EN (per-requester
//   saturating grant counters; tied to zero when undefined).
//   Ports:
//     clock, rstn_in      : clock, asynchronous active-low reset
//     enabled_in          : enable; deassertion starts drain
//     req_command_in      : per-requester command, valid = request
//     req_ready_out       : per-requester accept (one-hot or zero)
//     read_buffer_status  : downstream status, alfull throttles
//     read_response_in    : response return, valid retires one read
//     read_command_out    : granted command, one cycle after acceptance
//     grant_id_out        : requester index of read_command_out
//     outstanding_out     : current outstanding count
//     arb_idle_out        : idle with zero outstanding
//     grant_count_out     : per-requester grant counters
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int  NUM_REQUESTERS  = NUM_READ_ARB_REQUESTERS,
  parameter int  MAX_OUTSTANDING = READ_ARB_MAX_OUTSTANDING,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int IDX_W           = $clog2(NUM_REQUESTERS)
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  CommandBufferLine  req_command_in [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] req_ready_out,
  input  BufferStatus       read_buffer_status,
  input  ResponseBufferLine read_response_in,
  output CommandBufferLine  read_command_out,
  output logic [IDX_W-1:0]  grant_id_out,
  output logic [OUT_W-1:0]  outstanding_out,
  output logic              arb_idle_out,
  output logic [31:0]       grant_count_out [NUM_REQUESTERS]
);

  arb_state_type     state_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [OUT_W-1:0]  outstanding_reg;
  logic [OUT_W-1:0]  outstanding_next;
  CommandBufferLine  command_reg;
  logic [IDX_W-1:0]  grant_id_reg;
  logic              idle_reg;

  logic [NUM_REQUESTERS-1:0] request_valid;
  logic [NUM_REQUESTERS-1:0] grant_onehot;
  logic [IDX_W-1:0]          grant_index;
  logic                      grant_valid;
  logic                      can_issue;
  logic                      grant_fire;
  logic                      response_retire;
  logic                      at_full_next;

  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_req
      assign request_valid[gi] = req_command_in[gi].valid;
    end
  endgenerate

  round_robin_priority_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr (
    .request     (request_valid),
    .pointer     (rr_ptr_reg),
    .grant_onehot(grant_onehot),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  assign can_issue       = ~read_buffer_status.alfull & (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
  // Not gated by enabled_in: a command accepted in the cycle enable drops
  // still issues; the FSM leaves ARB_ACTIVE at the same edge.
  assign grant_fire      = (state_reg == ARB_ACTIVE) & can_issue & grant_valid;
  assign req_ready_out   = grant_fire ? grant_onehot : '0;
  // Responses with nothing outstanding belong to no tracked command.
  assign response_retire = read_response_in.valid & (outstanding_reg != '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    if (grant_fire && !response_retire)
      outstanding_next = outstanding_reg + 1'b1;
    else if (!grant_fire && response_retire)
      outstanding_next = outstanding_reg - 1'b1;
  end

  // Filling the last outstanding slot moves straight to ARB_STALL.
  assign at_full_next = (outstanding_next == OUT_W'(MAX_OUTSTANDING));

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      state_reg       <= ARB_IDLE;
      rr_ptr_reg      <= '0;
      outstanding_reg <= '0;
      command_reg     <= '0;
      grant_id_reg    <= '0;
      idle_reg        <= 1'b1;
    end else begin
      outstanding_reg <= outstanding_next;
      command_reg     <= grant_fire ? req_command_in[grant_index] : '0;
      if (grant_fire) begin
        grant_id_reg <= grant_index;
        rr_ptr_reg   <= (grant_index == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_index + 1'b1;
      end
      case (state_reg)
        ARB_IDLE: begin
          if (enabled_in) begin
            state_reg <= ARB_ACTIVE;
            idle_reg  <= 1'b0;
          end else begin
            idle_reg  <= 1'b1;
          end
        end
        ARB_ACTIVE: begin
          idle_reg <= 1'b0;
          if (!enabled_in)
            state_reg <= ARB_DRAIN;
          else if (!can_issue || at_full_next)
            state_reg <= ARB_STALL;
        end
        ARB_STALL: begin
          idle_reg <= 1'b0;
          if (!enabled_in)
            state_reg <= ARB_DRAIN;
          else if (can_issue)
            state_reg <= ARB_ACTIVE;
        end
        ARB_DRAIN: begin
          if (outstanding_reg == '0) begin
            state_reg <= ARB_IDLE;
            idle_reg  <= 1'b1;
          end else begin
            idle_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
          idle_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign read_command_out = command_reg;
  assign grant_id_out     = grant_id_reg;
  assign outstanding_out  = outstanding_reg;
  assign arb_idle_out     = idle_reg;

`ifdef CU_READ_ARB_GRANT_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_stats
      logic [31:0] count_reg;
      always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in)
          count_reg <= '0;
        else if (req_ready_out[gi] && (count_reg != 32'hFFFF_FFFF))
          count_reg <= count_reg + 1'b1;
      end
      assign grant_count_out[gi] = count_reg;
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_stats_off
      assign grant_count_out[gi] = '0;
    end
  endgenerate
`endif

  // Only valid/alfull are meaningful here; the rest passes through elsewhere.
  logic unused_status_bits;
  assign unused_status_bits = ^{read_buffer_status.full, read_buffer_status.empty,
                                read_response_in.tag, read_response_in.data};

  response_without_outstanding: assert property (
    @(posedge clock) disable iff (!rstn_in)
      !(read_response_in.valid && (outstanding_reg == '0)));

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;

  localparam int NR    = 4;
  localparam int MO    = 8;
  localparam int OUT_W = $clog2(MO + 1);
  localparam int IDX_W = $clog2(NR);

  logic              clock = 1'b0;
  logic              rstn_in;
  logic              enabled_in;
  CommandBufferLine  req_command_in [NR];
  logic [NR-1:0]     req_ready_out;
  BufferStatus       read_buffer_status;
  ResponseBufferLine read_response_in;
  CommandBufferLine  read_command_out;
  logic [IDX_W-1:0]  grant_id_out;
  logic [OUT_W-1:0]  outstanding_out;
  logic              arb_idle_out;
  logic [31:0]       grant_count_out [NR];

  always #5 clock = ~clock;

  cu_read_command_arbiter #(
    .NUM_REQUESTERS (NR),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clock             (clock),
    .rstn_in           (rstn_in),
    .enabled_in        (enabled_in),
    .req_command_in    (req_command_in),
    .req_ready_out     (req_ready_out),
    .read_buffer_status(read_buffer_status),
    .read_response_in  (read_response_in),
    .read_command_out  (read_command_out),
    .grant_id_out      (grant_id_out),
    .outstanding_out   (outstanding_out),
    .arb_idle_out      (arb_idle_out),
    .grant_count_out   (grant_count_out)
  );

  typedef struct {
    CommandBufferLine cmd;
    int               id;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          m_state;      // 0 idle, 1 active, 2 stall, 3 drain
  int          m_ptr;
  int          m_out;
  int          cyc;
  int          n_out;
  int          start;
  int          exp_cnt [NR];
  logic [NR-1:0] req_vec;
  logic        auto_resp;
  logic [7:0]  resp_sr;
  exp_t        sb [$];
  int          seen_ids [$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_requests();
    for (int i = 0; i < NR; i++) begin
      req_command_in[i].valid   = req_vec[i];
      req_command_in[i].address = 32'(cyc * 16 + i);
      req_command_in[i].tag     = 8'(i + 8'h40);
    end
  endtask

  task automatic reset_model();
    m_state = 0;
    m_ptr   = 0;
    m_out   = 0;
    resp_sr = '0;
    sb.delete();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_valid"}, 64'(read_command_out.valid), 64'(0));
    check({tag, "_cmd"}, 64'(read_command_out), 64'(0));
    check({tag, "_ready"}, 64'(req_ready_out), 64'(0));
    check({tag, "_gid"}, 64'(grant_id_out), 64'(0));
    check({tag, "_outst"}, 64'(outstanding_out), 64'(0));
    check({tag, "_idle"}, 64'(arb_idle_out), 64'(1));
    for (int k = 0; k < NR; k++)
      check({tag, "_gcount"}, 64'(grant_count_out[k]), 64'(0));
  endtask

  // One clock: predict the accept at the negedge, push the expected
  // command, then check the registered outputs just after the edge.
  task automatic cycle();
    logic [NR-1:0] exp_rdy;
    int   win;
    int   c;
    int   ns;
    int   out_n;
    logic can;
    logic resp_v;
    exp_t e;
    drive_requests();
    @(negedge clock);
    exp_rdy = '0;
    win     = -1;
    can     = !read_buffer_status.alfull && (m_out < MO);
    if (m_state == 1 && can) begin
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (win < 0 && req_vec[c]) win = c;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("ready", 64'(req_ready_out), 64'(exp_rdy));
    if (win >= 0) begin
      e.cmd = req_command_in[win];
      e.id  = win;
      sb.push_back(e);
      m_ptr = (win + 1) % NR;
    end
    resp_v = read_response_in.valid && (m_out > 0);
    out_n  = m_out + int'(win >= 0) - int'(resp_v);
    ns     = m_state;
    case (m_state)
      0: if (enabled_in) ns = 1;
      1: if (!enabled_in) ns = 3; else if (!can || out_n == MO) ns = 2;
      2: if (!enabled_in) ns = 3; else if (can) ns = 1;
      default: if (m_out == 0) ns = 0;
    endcase
    m_state = ns;
    m_out   = out_n;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cmd_valid", 64'(read_command_out.valid), 64'(1));
      check("cmd", 64'(read_command_out), 64'(e.cmd));
      check("grant_id", 64'(grant_id_out), 64'(e.id));
    end else begin
      check("cmd_valid", 64'(read_command_out.valid), 64'(0));
    end
    check("outstanding", 64'(outstanding_out), 64'(m_out));
    check("idle", 64'(arb_idle_out), 64'(m_state == 0 && m_out == 0));
    if (read_command_out.valid) begin
      n_out++;
      seen_ids.push_back(int'(grant_id_out));
    end
    cyc++;
    resp_sr = {resp_sr[6:0], read_command_out.valid & auto_resp};
    read_response_in       = '0;
    read_response_in.valid = resp_sr[4];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_in            = 1'b0;
    enabled_in         = 1'b0;
    req_vec            = '0;
    auto_resp          = 1'b0;
    read_buffer_status = '0;
    read_response_in   = '0;
    cyc                = 0;
    n_out              = 0;
    reset_model();
    drive_requests();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    rstn_in = 1'b1;
    @(posedge clock);
    #1;
    check_reset_values("post_reset");

    // All four requesting, responses 5 cycles after each output.
    enabled_in = 1'b1;
    req_vec    = 4'b1111;
    auto_resp  = 1'b1;
    seen_ids.delete();
    repeat (24) cycle();
    check("rr_total", 64'(seen_ids.size()), 64'(23));
    for (int k = 0; k < 8 && k < seen_ids.size(); k++)
      check("rr_order", 64'(seen_ids[k]), 64'(k % 4));
    check("steady_outstanding", 64'(outstanding_out), 64'(5));
`ifdef CU_READ_ARB_GRANT_STATS_EN
    exp_cnt = '{6, 6, 6, 5};
`else
    exp_cnt = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < NR; k++)
      check("grant_count", 64'(grant_count_out[k]), 64'(exp_cnt[k]));
    req_vec = '0;
    repeat (8) cycle();
    check("drained_1", 64'(outstanding_out), 64'(0));

    // Pointer sits at 3; only requester 2 -> wraps to 2, pointer back to 3.
    seen_ids.delete();
    req_vec = 4'b0100;
    cycle();
    check("wrap_grant_id", 64'(grant_id_out), 64'(2));
    req_vec = 4'b1001;
    cycle();
    check("ptr_after_wrap", 64'(grant_id_out), 64'(3));
    req_vec = '0;
    repeat (7) cycle();

    // Full window: exactly MO commands, then stall; one response -> one more.
    auto_resp = 1'b0;
    req_vec   = 4'b0001;
    start     = n_out;
    repeat (12) cycle();
    check("full_issued", 64'(n_out - start), 64'(MO));
    check("full_ready", 64'(req_ready_out), 64'(0));
    check("full_outstanding", 64'(outstanding_out), 64'(MO));
    start = n_out;
    read_response_in.valid = 1'b1;
    cycle();
    repeat (5) cycle();
    check("one_more_grant", 64'(n_out - start), 64'(1));
    req_vec = '0;
    repeat (MO) begin
      read_response_in.valid = 1'b1;
      cycle();
    end
    check("drained_2", 64'(outstanding_out), 64'(0));

    // alfull for 10 cycles blocks every grant.
    auto_resp = 1'b1;
    req_vec   = 4'b0010;
    repeat (4) cycle();
    read_buffer_status.alfull = 1'b1;
    start = n_out;
    repeat (10) cycle();
    check("alfull_no_issue", 64'(n_out - start), 64'(0));
    read_buffer_status.alfull = 1'b0;
    start = n_out;
    repeat (3) cycle();
    check("alfull_resume", 64'(n_out - start), 64'(2));
    req_vec = '0;
    repeat (8) cycle();
    auto_resp = 1'b0;

    // Drain: enable drops in the cycle of the third accept.
    req_vec = 4'b0001;
    start   = n_out;
    cycle();
    cycle();
    enabled_in = 1'b0;
    cycle();
    check("drain_last_accept", 64'(n_out - start), 64'(3));
    repeat (4) cycle();
    check("drain_no_grant", 64'(n_out - start), 64'(3));
    check("drain_outstanding", 64'(outstanding_out), 64'(3));
    check("drain_not_idle", 64'(arb_idle_out), 64'(0));
    repeat (3) begin
      read_response_in.valid = 1'b1;
      cycle();
    end
    check("drain_zero", 64'(outstanding_out), 64'(0));
    check("drain_idle_late", 64'(arb_idle_out), 64'(0));
    cycle();
    check("drain_idle", 64'(arb_idle_out), 64'(1));

    // Reset with 7 outstanding and commands still pending.
    enabled_in = 1'b1;
    req_vec    = 4'b1111;
    for (int k = 0; k < 20 && m_out < 7; k++) cycle();
    check("pre_reset_outstanding", 64'(outstanding_out), 64'(7));
    #2;
    rstn_in = 1'b0;
    #1;
    check_reset_values("async_reset");
    reset_model();
    enabled_in = 1'b0;
    repeat (2) cycle();
    rstn_in = 1'b1;
    cycle();
    check_reset_values("after_async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
